alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Issue controller between decode and the ALU stage.
- Decides each cycle whether the decoded instruction may enter the ALU.
- Tracks in-flight destination registers in a scoreboard to block RAW/WAW hazards.
- Sequences the multi-cycle MUL with a small FSM and latency counter, holding the result slot while the pipeline is stalled.

Parameters:
MUL_LATENCY, 5, cycles from MUL issue to mul_done (legal range >= 2)
RF_ADDR_WIDTH, 5, register-file address width
NUM_REGS, 32, number of architectural registers (2**RF_ADDR_WIDTH)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
dec_valid  in  1  decode presents an instruction
dec_opcode  in  `INSTR_OPCODE_RANGE  opcode; MUL = `INSTR_MUL_OPCODE
dec_rd_addr  in  RF_ADDR_WIDTH  destination register
dec_ra_addr  in  RF_ADDR_WIDTH  source A
dec_rb_addr  in  RF_ADDR_WIDTH  source B
dec_uses_ra  in  1  instruction reads ra
dec_uses_rb  in  1  instruction reads rb
dec_writes_rd  in  1  instruction writes rd
stall_alu  in  1  downstream stall
flush  in  1  taken branch; blocks issue this cycle
wb_valid  in  1  register-file write this cycle
wb_rd_addr  in  RF_ADDR_WIDTH  register written
dec_ready  out  1  instruction accepted this cycle (combinational)
alu_issue_valid  out  1  issue strobe to ALU; equals dec_ready
alu_issue_is_mul  out  1  issued instruction is MUL
mul_done  out  1  MUL result slot valid (level while in DONE)
mul_dst_reg  out  RF_ADDR_WIDTH  rd of in-flight MUL
busy_regs  out  NUM_REGS  scoreboard; bit i = write to reg i pending
mul_count  out  $clog2(MUL_LATENCY)+1  MUL latency counter (debug)

Behaviour:
- Reset (async, reset==0):
  - state=IDLE, mul_count=0, busy_regs=0, mul_dst_reg=0.
  - All combinational outputs evaluate to 0.
  - Reset mid-MUL abandons the MUL with no mul_done pulse.
- FSM states: IDLE, MUL_BUSY, MUL_DONE.
- hazard, per operand and masked by its dec_uses_*/dec_writes_rd qualifier:
  - (uses_ra & busy'[ra]) | (uses_rb & busy'[rb]) | (writes_rd & busy'[rd])
  - busy' = busy_regs with bit wb_rd_addr cleared when wb_valid (same-cycle writeback bypass).
- issue = dec_valid & state==IDLE & !stall_alu & !flush & !hazard; dec_ready = alu_issue_valid = issue.
- alu_issue_is_mul = issue & (dec_opcode == `INSTR_MUL_OPCODE).
- Scoreboard update each edge:
  - Clear bit wb_rd_addr if wb_valid; set bit dec_rd_addr if issue & dec_writes_rd.
  - Same-reg set and clear in one cycle: set wins.
  - Register 0 is never set.
  - Clearing an already-clear bit is a no-op.
- MUL sequencing (issue at cycle N):
  - IDLE -> MUL_BUSY on alu_issue_is_mul; mul_count=1 and mul_dst_reg=dec_rd_addr at N+1.
  - MUL_BUSY: mul_count increments each cycle regardless of stall_alu. At mul_count==MUL_LATENCY-1 -> MUL_DONE.
  - Result: mul_done=1 first at cycle N+MUL_LATENCY.
  - MUL_DONE: mul_done=1. If stall_alu, hold MUL_DONE (mul_done stays high). Else -> IDLE, mul_count=0.
  - No issue in MUL_BUSY or MUL_DONE (dec_ready=0). Next issue is earliest at N+MUL_LATENCY+1.
- flush:
  - Blocks issue that cycle only.
  - Does not cancel an in-flight MUL, which is older than the branch.
  - Does not clear scoreboard bits.
- Non-MUL issues never leave IDLE.
- Back-to-back single-cycle issues are allowed every cycle when hazard-free.

Test Plan:
1. Reset, then ADD r3<-r1,r2 with dec_valid=1 -> dec_ready=1 same cycle; busy_regs=0x8 next cycle; wb_valid with rd=3 -> busy_regs=0.
2. MUL r5 issued cycle 10, MUL_LATENCY=5 -> mul_count 1..4 on cycles 11..14; mul_done=1 at cycle 15, mul_dst_reg=5; dec_ready=0 on cycles 11..15; new issue accepted at 16.
3. ADD r4<-r3,r1 while busy_regs[3]=1 -> dec_ready=0; in the cycle wb_valid,wb_rd_addr=3 -> dec_ready=1 (bypass).
4. MUL completes while stall_alu=1 for cycles 15..17 -> mul_done held high 15..17; IDLE at 19 (stall released at 18).
5. flush=1 with a hazard-free dec_valid -> dec_ready=0 and busy_regs unchanged; flush during MUL_BUSY -> mul_done still at N+5.
6. reset to 0 at cycle 12 mid-MUL -> state IDLE, busy_regs=0, mul_count=0, no mul_done; writes_rd with rd=0 never sets busy_regs[0].

Source files
------------

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : decode-to-ALU issue gate with RAW/WAW scoreboard and MUL sequencer
// Revision : 1.0 - initial release
// ============================================================================

`ifndef INSTR_OPCODE_RANGE
`define INSTR_OPCODE_RANGE 5:0
`endif
`ifndef INSTR_MUL_OPCODE
`define INSTR_MUL_OPCODE 6'h0c
`endif

module alu_issue_ctrl #(
  parameter int MUL_LATENCY   = 5,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int NUM_REGS      = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            dec_valid,
  input  logic [`INSTR_OPCODE_RANGE]      dec_opcode,
  input  logic [RF_ADDR_WIDTH-1:0]        dec_rd_addr,
  input  logic [RF_ADDR_WIDTH-1:0]        dec_ra_addr,
  input  logic [RF_ADDR_WIDTH-1:0]        dec_rb_addr,
  input  logic                            dec_uses_ra,
  input  logic                            dec_uses_rb,
  input  logic                            dec_writes_rd,
  input  logic                            stall_alu,
  input  logic                            flush,
  input  logic                            wb_valid,
  input  logic [RF_ADDR_WIDTH-1:0]        wb_rd_addr,
  output logic                            dec_ready,
  output logic                            alu_issue_valid,
  output logic                            alu_issue_is_mul,
  output logic                            mul_done,
  output logic [RF_ADDR_WIDTH-1:0]        mul_dst_reg,
  output logic [NUM_REGS-1:0]             busy_regs,
  output logic [$clog2(MUL_LATENCY):0]    mul_count
);

  localparam int CW = $clog2(MUL_LATENCY) + 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MUL_BUSY = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

  localparam logic [CW-1:0] c_mul_last = CW'(MUL_LATENCY - 1);

  logic [1:0]               r_state;
  logic [CW-1:0]            r_mul_count;
  logic [RF_ADDR_WIDTH-1:0] r_mul_dst;
  logic [NUM_REGS-1:0]      r_busy;

  logic [NUM_REGS-1:0]      w_busy_bypass;
  logic [NUM_REGS-1:0]      w_busy_next;
  logic                     w_hazard;
  logic                     w_issue;
  logic                     w_is_mul;

  // A writeback landing this cycle releases its register to the instruction
  // being decoded now, so the scoreboard view is taken after the clear.
  always_comb begin
    w_busy_bypass = r_busy;
    if (wb_valid)
      w_busy_bypass[wb_rd_addr] = 1'b0;

    w_hazard = (dec_uses_ra   & w_busy_bypass[dec_ra_addr]) |
               (dec_uses_rb   & w_busy_bypass[dec_rb_addr]) |
               (dec_writes_rd & w_busy_bypass[dec_rd_addr]);

    // Gating with reset keeps every combinational output low while in reset.
    w_issue  = reset & dec_valid & (r_state == IDLE) & ~stall_alu & ~flush & ~w_hazard;
    w_is_mul = w_issue & (dec_opcode == `INSTR_MUL_OPCODE);

    w_busy_next = w_busy_bypass;
    if (w_issue && dec_writes_rd && (dec_rd_addr != '0))
      w_busy_next[dec_rd_addr] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_busy <= '0;
    else
      r_busy <= w_busy_next;
  end

  // The counter keeps running under stall; only the finished result waits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_mul_count <= '0;
      r_mul_dst   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_is_mul) begin
            r_state     <= MUL_BUSY;
            r_mul_count <= CW'(1);
            r_mul_dst   <= dec_rd_addr;
          end
        end
        MUL_BUSY: begin
          r_mul_count <= r_mul_count + CW'(1);
          if (r_mul_count == c_mul_last)
            r_state <= MUL_DONE;
        end
        MUL_DONE: begin
          if (!stall_alu) begin
            r_state     <= IDLE;
            r_mul_count <= '0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_mul_count <= '0;
        end
      endcase
    end
  end

  assign dec_ready        = w_issue;
  assign alu_issue_valid  = w_issue;
  assign alu_issue_is_mul = w_is_mul;
  assign mul_done         = (r_state == MUL_DONE);
  assign mul_dst_reg      = r_mul_dst;
  assign busy_regs        = r_busy;
  assign mul_count        = r_mul_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : directed self-checking bench for alu_issue_ctrl
// Revision : 1.0 - initial release
// ============================================================================

`ifndef INSTR_OPCODE_RANGE
`define INSTR_OPCODE_RANGE 5:0
`endif
`ifndef INSTR_MUL_OPCODE
`define INSTR_MUL_OPCODE 6'h0c
`endif

module tb_alu_issue_ctrl;

  localparam logic [5:0] c_op_add = 6'h01;
  localparam logic [5:0] c_op_mul = `INSTR_MUL_OPCODE;

  logic                       clock = 1'b0;
  logic                       reset;
  logic                       dec_valid;
  logic [`INSTR_OPCODE_RANGE] dec_opcode;
  logic [4:0]                 dec_rd_addr, dec_ra_addr, dec_rb_addr;
  logic                       dec_uses_ra, dec_uses_rb, dec_writes_rd;
  logic                       stall_alu, flush, wb_valid;
  logic [4:0]                 wb_rd_addr;
  logic                       dec_ready, alu_issue_valid, alu_issue_is_mul, mul_done;
  logic [4:0]                 mul_dst_reg;
  logic [31:0]                busy_regs;
  logic [3:0]                 mul_count;

  int total = 0;
  int bad   = 0;

  alu_issue_ctrl #(.MUL_LATENCY(5), .RF_ADDR_WIDTH(5), .NUM_REGS(32)) dut (
    .clock(clock), .reset(reset),
    .dec_valid(dec_valid), .dec_opcode(dec_opcode),
    .dec_rd_addr(dec_rd_addr), .dec_ra_addr(dec_ra_addr), .dec_rb_addr(dec_rb_addr),
    .dec_uses_ra(dec_uses_ra), .dec_uses_rb(dec_uses_rb), .dec_writes_rd(dec_writes_rd),
    .stall_alu(stall_alu), .flush(flush),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
    .dec_ready(dec_ready), .alu_issue_valid(alu_issue_valid),
    .alu_issue_is_mul(alu_issue_is_mul), .mul_done(mul_done),
    .mul_dst_reg(mul_dst_reg), .busy_regs(busy_regs), .mul_count(mul_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks follow another unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_in();
    dec_valid = 0; dec_opcode = c_op_add;
    dec_rd_addr = 0; dec_ra_addr = 0; dec_rb_addr = 0;
    dec_uses_ra = 0; dec_uses_rb = 0; dec_writes_rd = 0;
    stall_alu = 0; flush = 0; wb_valid = 0; wb_rd_addr = 0;
  endtask

  task automatic dec(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] ra,
                     input logic [4:0] rb, input logic ua, input logic ub, input logic wr);
    dec_valid = 1; dec_opcode = op;
    dec_rd_addr = rd; dec_ra_addr = ra; dec_rb_addr = rb;
    dec_uses_ra = ua; dec_uses_rb = ub; dec_writes_rd = wr;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid = 1; wb_rd_addr = rd;
  endtask

  initial begin
    reset = 0;
    clr_in();
    // Reset: hazard-free decode must still see zero outputs.
    dec(c_op_mul, 5'd3, 5'd1, 5'd2, 1, 1, 1);
    tick(); settle();
    chk("rst_ready", dec_ready, 0);
    chk("rst_is_mul", alu_issue_is_mul, 0);
    chk("rst_busy", busy_regs, 0);
    chk("rst_count", mul_count, 0);
    chk("rst_done", mul_done, 0);
    chk("rst_dst", mul_dst_reg, 0);
    tick();
    clr_in(); reset = 1;
    tick();

    // ADD r3 <- r1, r2
    dec(c_op_add, 5'd3, 5'd1, 5'd2, 1, 1, 1); settle();
    chk("add_ready", dec_ready, 1);
    chk("add_valid", alu_issue_valid, 1);
    chk("add_is_mul", alu_issue_is_mul, 0);
    tick(); clr_in(); settle();
    chk("add_busy", busy_regs, 32'h8);

    // ADD r4 <- r3, r1 : RAW on r3, then released by same-cycle writeback
    dec(c_op_add, 5'd4, 5'd3, 5'd1, 1, 1, 1); settle();
    chk("raw_block", dec_ready, 0);
    tick(); settle();
    chk("raw_block2", dec_ready, 0);
    chk("raw_busy_hold", busy_regs, 32'h8);
    wb(5'd3); settle();
    chk("raw_bypass", dec_ready, 1);
    tick(); clr_in(); settle();
    chk("raw_busy_after", busy_regs, 32'h10);

    // WAW on r4 with no sources used
    dec(c_op_add, 5'd4, 5'd0, 5'd0, 0, 0, 1); settle();
    chk("waw_block", dec_ready, 0);
    tick(); clr_in(); wb(5'd4); tick(); clr_in(); settle();
    chk("wb_clear", busy_regs, 0);

    // Set wins over same-register clear; clearing a clear bit is harmless
    dec(c_op_add, 5'd6, 5'd0, 5'd0, 0, 0, 1); wb(5'd6); settle();
    chk("setwin_ready", dec_ready, 1);
    tick(); clr_in(); settle();
    chk("setwin_busy", busy_regs, 32'h40);

    // Flush blocks a hazard-free issue and keeps the scoreboard
    dec(c_op_add, 5'd7, 5'd1, 5'd2, 1, 1, 1); flush = 1; settle();
    chk("flush_ready", dec_ready, 0);
    tick(); clr_in(); settle();
    chk("flush_busy", busy_regs, 32'h40);
    wb(5'd6); tick(); clr_in(); settle();
    chk("flush_wb", busy_regs, 0);

    // MUL r5 at cycle N with latency 5, flush during MUL_BUSY
    dec(c_op_mul, 5'd5, 5'd1, 5'd2, 1, 1, 1); settle();
    chk("mul_ready", dec_ready, 1);
    chk("mul_is_mul", alu_issue_is_mul, 1);
    tick(); clr_in();
    dec(c_op_add, 5'd9, 5'd0, 5'd0, 0, 0, 1); settle();
    chk("mul_c1", mul_count, 1);
    chk("mul_dst", mul_dst_reg, 5);
    chk("mul_busy_block", dec_ready, 0);
    chk("mul_c1_done", mul_done, 0);
    for (int k = 2; k <= 4; k++) begin
      tick(); flush = (k == 2); settle();
      chk($sformatf("mul_c%0d", k), mul_count, 32'(k));
      chk($sformatf("mul_block%0d", k), dec_ready, 0);
      chk($sformatf("mul_nodone%0d", k), mul_done, 0);
    end
    tick(); flush = 0; settle();
    chk("mul_done_n5", mul_done, 1);
    chk("mul_done_block", dec_ready, 0);
    chk("mul_done_dst", mul_dst_reg, 5);
    tick(); settle();
    chk("mul_after_done", mul_done, 0);
    chk("mul_after_count", mul_count, 0);
    chk("mul_next_issue", dec_ready, 1);
    tick(); clr_in(); settle();
    chk("mul_busy_regs", busy_regs, 32'h220);
    wb(5'd5); tick(); wb(5'd9); tick(); clr_in(); settle();
    chk("mul_wb_clear", busy_regs, 0);

    // MUL completing under stall: done held while stalled, one extra cycle after release
    dec(c_op_mul, 5'd5, 5'd0, 5'd0, 0, 0, 1); settle();
    chk("stl_issue", alu_issue_is_mul, 1);
    tick(); clr_in();
    tick(); tick(); stall_alu = 1; settle();
    chk("stl_count3", mul_count, 3);
    tick(); settle();
    chk("stl_count4", mul_count, 4);
    for (int k = 5; k <= 7; k++) begin
      tick(); settle();
      chk($sformatf("stl_hold%0d", k), mul_done, 1);
    end
    tick(); stall_alu = 0;
    dec(c_op_add, 5'd8, 5'd0, 5'd0, 0, 0, 1); settle();
    chk("stl_release_done", mul_done, 1);
    chk("stl_release_block", dec_ready, 0);
    tick(); clr_in(); settle();
    chk("stl_idle", mul_done, 0);
    chk("stl_idle_count", mul_count, 0);
    wb(5'd5); tick(); clr_in(); settle();
    chk("stl_wb", busy_regs, 0);

    // Reset mid-MUL abandons it
    dec(c_op_mul, 5'd5, 5'd0, 5'd0, 0, 0, 1);
    tick(); clr_in(); tick(); settle();
    chk("rmid_count2", mul_count, 2);
    reset = 0; settle();
    chk("rmid_count", mul_count, 0);
    chk("rmid_busy", busy_regs, 0);
    chk("rmid_done", mul_done, 0);
    tick(); reset = 1;
    for (int k = 0; k < 6; k++) begin
      tick(); settle();
      chk($sformatf("rmid_nodone%0d", k), mul_done, 0);
    end

    // Writes to r0 never mark the scoreboard
    dec(c_op_add, 5'd0, 5'd1, 5'd2, 1, 1, 1); settle();
    chk("r0_ready", dec_ready, 1);
    tick(); clr_in(); settle();
    chk("r0_busy", busy_regs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
